cplx_delay_line: RTL and testbench
==================================

// Module: cplx_delay_line
// PURPOSE
//  Parametrised complex (re/img) sample delay line for FFT stage alignment.
//  Runtime-programmable delay, clock-enable stall, per-sample valid, sync flush.
//  Sits between butterfly stages and twiddle multipliers wherever a fixed
//  N-cycle realignment is needed.
// PARAMETERS
//  DW        32   width of each of re / img
//  MAX_DLY   16   maximum delay in ce-cycles (storage depth)
//  DEF_DLY   9    delay loaded at reset (1..MAX_DLY)
//  LW        $clog2(MAX_DLY+1)  width of delay fields (localparam, derived)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  ce         in   1    clock enable; pipeline advances only when 1
//  flush      in   1    sync clear of in-flight valids and fill count
//  dly_ld     in   1    load dly_in into the delay register
//  dly_in     in   LW   requested delay; 0 -> 1, >MAX_DLY -> MAX_DLY
//  in_valid   in   1    input sample qualifier
//  in_re      in   DW   input real part
//  in_img     in   DW   input imaginary part
//  out_valid  out  1    in_valid delayed by dly_cur ce-cycles
//  out_re     out  DW   in_re delayed by dly_cur ce-cycles
//  out_img    out  DW   in_img delayed by dly_cur ce-cycles
//  primed     out  1    dly_cur ce-cycles elapsed since reset/flush/load
//  dly_cur    out  LW   delay currently in effect
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - all storage, out_re/out_img/out_valid = 0
//   - primed = 0; dly_cur = DEF_DLY; fill counter = 0
//  Datapath: sample on in_* at ce-cycle k appears on out_* at ce-cycle k+dly_cur.
//   - Outputs are registered.
//   - With ce held 1 and dly_cur=9, latency = 9 clocks.
//  ce=0:
//   - all storage, outputs and fill counter hold
//   - in_* is ignored (not captured); upstream must hold its data
//  dly_ld=1 (acts regardless of ce):
//   - dly_cur <= clamp(dly_in) next edge
//   - all in-flight valid bits and out_valid cleared; fill counter = 0
//   - data bits are not cleared (don't-care while valid=0)
//  flush=1 (regardless of ce):
//   - valid bits cleared; out_valid <= 0; fill counter = 0
//   - dly_cur unchanged
//  flush and dly_ld in the same cycle: both effects apply.
//  A sample with in_valid=1 accepted during flush/dly_ld cycle is dropped.
//  Fill counter / primed:
//   - counts ce=1 cycles, saturating at dly_cur
//   - primed=1 when count==dly_cur; stays 1 until next reset/flush/dly_ld
//  Widths: no arithmetic on data; bit-exact pass-through of re/img.
// TESTING
//  1. Reset, ce=1, ramp in_re=1..20 (in_img=~in_re), in_valid=1 ->
//     out_re=1 at clk 9, out_re=n at clk n+8; primed rises clk 9.
//  2. dly_ld with dly_in=3 mid-stream ->
//     out_valid=0 for 3 clocks, then in data delayed by 3; dly_cur=3.
//  3. dly_in=0 -> dly_cur=1; dly_in=31 with MAX_DLY=16 -> dly_cur=16,
//     latency 16.
//  4. ce toggled 1010... with dly=4 -> each sample emerges after 4 ce-high
//     edges (8 clocks); outputs stable while ce=0.
//  5. flush at clk 5 of a valid burst ->
//     no out_valid from pre-flush samples; primed=0 until 9 ce-cycles later.
//  6. rst_n low asynchronously mid-burst (between edges) ->
//     outputs 0 immediately; dly_cur=9 after release.

Source files
------------

// File: rtl/cplx_delay_line.sv
// ----------------------------------------------------------------------------
// cplx_delay_line
//   Complex (re/img) sample delay line used to realign data between FFT
//   butterfly stages and twiddle multipliers. The delay is programmable at
//   run time. A clock enable stalls the whole pipeline. Each sample carries a
//   valid bit, and a synchronous flush discards everything in flight.
//
//   The delay is built from a shift register. The output register acts as
//   the final stage, so a delay of D ce-cycles uses D-1 storage stages plus
//   the output register. The tap feeding the output register is chosen from
//   the delay currently in effect.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ce         in   clock enable; pipeline advances only when 1
//   flush      in   synchronous clear of in-flight valids and fill count
//   dly_ld     in   load clamped dly_in into the delay register
//   dly_in     in   requested delay (0 -> 1, >MAX_DLY -> MAX_DLY)
//   in_valid   in   input sample qualifier
//   in_re      in   input real part
//   in_img     in   input imaginary part
//   out_valid  out  in_valid delayed by dly_cur ce-cycles
//   out_re     out  in_re delayed by dly_cur ce-cycles
//   out_img    out  in_img delayed by dly_cur ce-cycles
//   primed     out  dly_cur ce-cycles elapsed since reset/flush/load
//   dly_cur    out  delay currently in effect
// ----------------------------------------------------------------------------
module cplx_delay_line #(
  parameter int DW      = 32,
  parameter int MAX_DLY = 16,
  parameter int DEF_DLY = 9,
  localparam int LW     = $clog2(MAX_DLY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          flush,
  input  logic          dly_ld,
  input  logic [LW-1:0] dly_in,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          out_valid,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_img,
  output logic          primed,
  output logic [LW-1:0] dly_cur
);

  // Index width for the storage array; MAX_DLY is at least 2.
  localparam int IW = (MAX_DLY > 2) ? $clog2(MAX_DLY) : 1;

  // Limit a requested delay to the legal range 1..MAX_DLY.
  function automatic logic [LW-1:0] clamp_dly(input logic [LW-1:0] d);
    logic [LW-1:0] r;
    if (d == {LW{1'b0}}) begin
      r = LW'(1);
    end else if (d > LW'(MAX_DLY)) begin
      r = LW'(MAX_DLY);
    end else begin
      r = d;
    end
    return r;
  endfunction

  logic [DW-1:0]      sr_re_r  [MAX_DLY];
  logic [DW-1:0]      sr_img_r [MAX_DLY];
  logic [MAX_DLY-1:0] sr_vld_r;
  logic [DW-1:0]      out_re_r;
  logic [DW-1:0]      out_img_r;
  logic               out_valid_r;
  logic [LW-1:0]      dly_cur_r;
  logic [LW-1:0]      fill_cnt_r;
  logic               primed_r;

  logic               clr_s;
  logic [IW-1:0]      tap_idx_s;
  logic [DW-1:0]      tap_re_s;
  logic [DW-1:0]      tap_img_s;
  logic               tap_vld_s;

  // Flush and delay load both discard in-flight samples, and so does the
  // sample presented during that cycle.
  assign clr_s = flush | dly_ld;

  // Select the stage feeding the output register; delay 1 bypasses storage.
  always_comb begin
    tap_idx_s = {IW{1'b0}};
    tap_re_s  = in_re;
    tap_img_s = in_img;
    tap_vld_s = in_valid;
    if (dly_cur_r > LW'(1)) begin
      tap_idx_s = IW'(dly_cur_r - LW'(2));
      tap_re_s  = sr_re_r[tap_idx_s];
      tap_img_s = sr_img_r[tap_idx_s];
      tap_vld_s = sr_vld_r[tap_idx_s];
    end else begin
      tap_re_s  = in_re;
      tap_img_s = in_img;
      tap_vld_s = in_valid;
    end
  end

  // Data storage shifts on ce; it is never cleared by flush or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_DLY; i++) begin
        sr_re_r[i]  <= {DW{1'b0}};
        sr_img_r[i] <= {DW{1'b0}};
      end
    end else if (ce) begin
      sr_re_r[0]  <= in_re;
      sr_img_r[0] <= in_img;
      for (int i = 1; i < MAX_DLY; i++) begin
        sr_re_r[i]  <= sr_re_r[i-1];
        sr_img_r[i] <= sr_img_r[i-1];
      end
    end else begin
      for (int i = 0; i < MAX_DLY; i++) begin
        sr_re_r[i]  <= sr_re_r[i];
        sr_img_r[i] <= sr_img_r[i];
      end
    end
  end

  // Valid bits shift with the data, but a clear wins even while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld_r <= {MAX_DLY{1'b0}};
    end else if (clr_s) begin
      sr_vld_r <= {MAX_DLY{1'b0}};
    end else if (ce) begin
      sr_vld_r <= {sr_vld_r[MAX_DLY-2:0], in_valid};
    end else begin
      sr_vld_r <= sr_vld_r;
    end
  end

  // Output data register: the last stage of the delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_re_r  <= {DW{1'b0}};
      out_img_r <= {DW{1'b0}};
    end else if (ce) begin
      out_re_r  <= tap_re_s;
      out_img_r <= tap_img_s;
    end else begin
      out_re_r  <= out_re_r;
      out_img_r <= out_img_r;
    end
  end

  // Output valid register: cleared by flush/load regardless of ce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else if (clr_s) begin
      out_valid_r <= 1'b0;
    end else if (ce) begin
      out_valid_r <= tap_vld_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Delay register: loads the clamped request whenever dly_ld is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cur_r <= LW'(DEF_DLY);
    end else if (dly_ld) begin
      dly_cur_r <= clamp_dly(dly_in);
    end else begin
      dly_cur_r <= dly_cur_r;
    end
  end

  // Fill counter saturates at the delay; primed marks a full pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= {LW{1'b0}};
      primed_r   <= 1'b0;
    end else if (clr_s) begin
      fill_cnt_r <= {LW{1'b0}};
      primed_r   <= 1'b0;
    end else if (ce) begin
      if (fill_cnt_r < dly_cur_r) begin
        fill_cnt_r <= fill_cnt_r + LW'(1);
        primed_r   <= ((fill_cnt_r + LW'(1)) == dly_cur_r);
      end else begin
        fill_cnt_r <= fill_cnt_r;
        primed_r   <= 1'b1;
      end
    end else begin
      fill_cnt_r <= fill_cnt_r;
      primed_r   <= primed_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_re    = out_re_r;
  assign out_img   = out_img_r;
  assign primed    = primed_r;
  assign dly_cur   = dly_cur_r;

endmodule

// File: tb/tb_cplx_delay_line.sv
// ----------------------------------------------------------------------------
// tb_cplx_delay_line
//   Self-checking bench for cplx_delay_line. A reference model keeps the
//   history of accepted samples (newest first) and predicts the output as the
//   sample accepted dly_cur ce-cycles ago. Directed phases cover the ramp,
//   delay reload, clamping, ce stalls, flush and asynchronous reset. A random
//   phase follows them.
// ----------------------------------------------------------------------------
module tb_cplx_delay_line;

  localparam int DW      = 32;
  localparam int MAX_DLY = 16;
  localparam int DEF_DLY = 9;
  localparam int LW      = $clog2(MAX_DLY + 1);

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic          flush;
  logic          dly_ld;
  logic [LW-1:0] dly_in;
  logic          in_valid;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_img;
  logic          out_valid;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_img;
  logic          primed;
  logic [LW-1:0] dly_cur;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_v [MAX_DLY];
  logic [DW-1:0] m_r [MAX_DLY];
  logic [DW-1:0] m_i [MAX_DLY];
  int            e_dly;
  int            e_cnt;
  logic          e_ov;
  logic [DW-1:0] e_or;
  logic [DW-1:0] e_oi;

  cplx_delay_line #(.DW(DW), .MAX_DLY(MAX_DLY), .DEF_DLY(DEF_DLY)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .flush(flush), .dly_ld(dly_ld),
    .dly_in(dly_in), .in_valid(in_valid), .in_re(in_re), .in_img(in_img),
    .out_valid(out_valid), .out_re(out_re), .out_img(out_img),
    .primed(primed), .dly_cur(dly_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAX_DLY; i++) begin
      m_v[i] = 1'b0;
      m_r[i] = '0;
      m_i[i] = '0;
    end
    e_dly = DEF_DLY;
    e_cnt = 0;
    e_ov  = 1'b0;
    e_or  = '0;
    e_oi  = '0;
  endtask

  // Compare all observable outputs with the model's prediction.
  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(e_ov));
    check({tag, ".dly"}, 64'(dly_cur), 64'(e_dly));
    check({tag, ".primed"}, 64'(primed), 64'(e_cnt == e_dly));
    if (e_ov) begin
      check({tag, ".re"}, 64'(out_re), 64'(e_or));
      check({tag, ".img"}, 64'(out_img), 64'(e_oi));
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, then check.
  task automatic tick(input string tag, input logic c, input logic f, input logic l,
                      input int d, input logic v, input logic [DW-1:0] r,
                      input logic [DW-1:0] im);
    ce = c; flush = f; dly_ld = l; dly_in = LW'(d);
    in_valid = v; in_re = r; in_img = im;
    @(posedge clk);
    if (f || l) begin
      for (int i = 0; i < MAX_DLY; i++) m_v[i] = 1'b0;
      e_ov  = 1'b0;
      e_cnt = 0;
    end
    if (l) e_dly = (d == 0) ? 1 : ((d > MAX_DLY) ? MAX_DLY : d);
    if (c) begin
      for (int i = MAX_DLY - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_r[i] = m_r[i-1];
        m_i[i] = m_i[i-1];
      end
      m_v[0] = v & ~(f | l);
      m_r[0] = r;
      m_i[0] = im;
      e_ov = m_v[e_dly-1];
      e_or = m_r[e_dly-1];
      e_oi = m_i[e_dly-1];
      if (!(f || l) && e_cnt < e_dly) e_cnt++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] rv;
    int            first_seen;
    rst_n = 1'b0; ce = 1'b0; flush = 1'b0; dly_ld = 1'b0; dly_in = '0;
    in_valid = 1'b0; in_re = '0; in_img = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.re", 64'(out_re), 64'd0);
    check("reset.img", 64'(out_img), 64'd0);
    check("reset.valid", 64'(out_valid), 64'd0);
    check("reset.primed", 64'(primed), 64'd0);
    check("reset.dly", 64'(dly_cur), 64'(DEF_DLY));
    rst_n = 1'b1;

    // Ramp 1..20 with the default delay: out_re = n after clock n+8.
    for (int n = 1; n <= 20; n++) begin
      rv = DW'(n);
      tick("ramp", 1'b1, 1'b0, 1'b0, 0, 1'b1, rv, ~rv);
      if (n == 8) check("ramp.primed_low8", 64'(primed), 64'd0);
      if (n == 9) begin
        check("ramp.first_out", 64'(out_re), 64'd1);
        check("ramp.primed_at9", 64'(primed), 64'd1);
      end
      if (n == 20) check("ramp.out20", 64'(out_re), 64'd12);
    end

    // Reload the delay to 3 while data keeps streaming.
    tick("ld3", 1'b1, 1'b0, 1'b1, 3, 1'b1, 32'h100, ~32'h100);
    for (int n = 1; n <= 8; n++) begin
      rv = DW'(32'h100 + n);
      tick("dly3", 1'b1, 1'b0, 1'b0, 0, 1'b1, rv, ~rv);
      if (n <= 2) check("dly3.gap", 64'(out_valid), 64'd0);
      if (n == 3) check("dly3.first", 64'(out_re), 64'h101);
    end

    // Clamping: 0 gives 1, 31 gives 16.
    tick("ld0", 1'b1, 1'b0, 1'b1, 0, 1'b0, '0, '0);
    for (int n = 0; n < 4; n++) begin
      rv = $urandom;
      tick("dly1", 1'b1, 1'b0, 1'b0, 0, 1'b1, rv, ~rv);
    end
    tick("ld31", 1'b1, 1'b0, 1'b1, 31, 1'b0, '0, '0);
    first_seen = 0;
    for (int n = 1; n <= 20; n++) begin
      tick("dly16", 1'b1, 1'b0, 1'b0, 0, (n == 1), 32'hCAFE0000 + DW'(n), DW'(n));
      if (out_valid && first_seen == 0) first_seen = n;
    end
    check("dly16.latency", 64'(first_seen), 64'd16);

    // ce toggling 1010 with delay 4: each sample needs 4 ce-high edges.
    tick("ld4", 1'b1, 1'b0, 1'b1, 4, 1'b0, '0, '0);
    for (int n = 0; n < 24; n++) begin
      rv = $urandom;
      tick("ce_tog", (n % 2 == 0), 1'b0, 1'b0, 0, 1'b1, rv, rv ^ 32'h5A5A5A5A);
    end

    // Flush part-way through a valid burst at the default delay.
    tick("ld9", 1'b1, 1'b0, 1'b1, 9, 1'b0, '0, '0);
    for (int n = 1; n <= 22; n++) begin
      rv = $urandom;
      tick("flush", 1'b1, (n == 5), 1'b0, 0, (n < 5), rv, ~rv);
      if (n > 5) check("flush.no_valid", 64'(out_valid), 64'd0);
      if (n == 13) check("flush.primed_low", 64'(primed), 64'd0);
      if (n == 14) check("flush.primed_high", 64'(primed), 64'd1);
    end

    // Asynchronous reset asserted between edges in the middle of a burst.
    for (int n = 0; n < 12; n++) begin
      rv = $urandom;
      tick("pre_arst", 1'b1, 1'b0, 1'b0, 0, 1'b1, rv, ~rv);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.re", 64'(out_re), 64'd0);
    check("arst.img", 64'(out_img), 64'd0);
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.primed", 64'(primed), 64'd0);
    check("arst.dly", 64'(dly_cur), 64'(DEF_DLY));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with occasional stalls, flushes and reloads.
    for (int n = 0; n < 400; n++) begin
      rv = $urandom;
      tick("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 29) == 0), int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), rv, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
